// File: rtl/mux_arbitrado_if.sv
// Bus between a producer of packed channel data and the arbitrated mux.
// The master drives the channels, mode and downstream ready. The slave
// returns the grants and the registered output word.
interface mux_arbitrado_if #(
  parameter int LARGURA     = 32,
  parameter int CANAIS      = 3,
  parameter int LARGURA_SEL = 2
);
  logic [CANAIS*LARGURA-1:0] entradas;
  logic [CANAIS-1:0]         validos;
  logic [CANAIS-1:0]         aceito;
  logic                      modo;
  logic [LARGURA_SEL-1:0]    seletor;
  logic [LARGURA-1:0]        saida;
  logic                      saida_valida;
  logic                      saida_pronta;
  logic [LARGURA_SEL-1:0]    canal_saida;
  logic                      erro_seletor;

  modport master (
    output entradas, validos, modo, seletor, saida_pronta,
    input  aceito, saida, saida_valida, canal_saida, erro_seletor
  );

  modport slave (
    input  entradas, validos, modo, seletor, saida_pronta,
    output aceito, saida, saida_valida, canal_saida, erro_seletor
  );
endinterface

// File: rtl/mux_arbitrado.sv
// Arbitrated N:1 mux feeding a one-word output register.
// Mode 0 picks the channel named by seletor; mode 1 is round-robin
// starting after the last channel granted in mode 1. The output register
// reloads in the same cycle it is drained, so throughput is one word/cycle.
module mux_arbitrado #(
  parameter int LARGURA     = 32,
  parameter int CANAIS      = 3,
  parameter int LARGURA_SEL = 2
) (
  input  logic            clock,
  input  logic            reset,
  mux_arbitrado_if.slave  bus
);

  logic [LARGURA-1:0]     r_saida;
  logic                   r_saida_valida;
  logic [LARGURA_SEL-1:0] r_canal_saida;
  logic [LARGURA_SEL-1:0] r_ultimo;
  logic                   r_erro_seletor;

  int                     w_sel;
  logic                   w_sel_ok;
  logic                   w_livre;
  logic                   w_cand_vld;
  int                     w_cand;
  logic                   w_carga;
  logic [2*CANAIS-1:0]    w_validos_dup;
  logic [LARGURA-1:0]     w_dado;

  // Decode the fixed-mode selector and the register-free condition.
  always_comb begin
    w_sel    = int'(bus.seletor);
    w_sel_ok = (w_sel < CANAIS);
    w_livre  = !r_saida_valida || bus.saida_pronta;
  end

  // Pick the candidate channel; round-robin scans a doubled valid vector
  // over the window (ultimo, ultimo+CANAIS] so the wrap is a plain compare.
  always_comb begin
    w_cand_vld    = 1'b0;
    w_cand        = 0;
    w_validos_dup = {bus.validos, bus.validos};
    if (bus.modo) begin
      for (int j = 0; j < 2*CANAIS; j++) begin
        if (!w_cand_vld && (j > int'(r_ultimo)) &&
            (j <= int'(r_ultimo) + CANAIS) && w_validos_dup[j]) begin
          w_cand_vld = 1'b1;
          w_cand     = (j >= CANAIS) ? j - CANAIS : j;
        end
      end
    end else begin
      for (int i = 0; i < CANAIS; i++) begin
        if (w_sel_ok && (i == w_sel) && bus.validos[i]) begin
          w_cand_vld = 1'b1;
          w_cand     = i;
        end
      end
    end
  end

  // One-hot grant and data select for the chosen channel; no grant in reset.
  always_comb begin
    w_carga    = !reset && w_livre && w_cand_vld;
    bus.aceito = '0;
    w_dado     = '0;
    for (int i = 0; i < CANAIS; i++) begin
      if (w_cand == i) begin
        bus.aceito[i] = w_carga;
        w_dado        = bus.entradas[i*LARGURA +: LARGURA];
      end
    end
  end

  // Output register, round-robin pointer and selector error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_saida        <= '0;
      r_saida_valida <= 1'b0;
      r_canal_saida  <= '0;
      r_erro_seletor <= 1'b0;
      r_ultimo       <= LARGURA_SEL'(CANAIS - 1);
    end else begin
      r_erro_seletor <= !bus.modo && !w_sel_ok;
      if (w_livre) begin
        if (w_cand_vld) begin
          r_saida        <= w_dado;
          r_canal_saida  <= LARGURA_SEL'(w_cand);
          r_saida_valida <= 1'b1;
          if (bus.modo) begin
            r_ultimo <= LARGURA_SEL'(w_cand);
          end
        end else begin
          r_saida_valida <= 1'b0;
        end
      end
    end
  end

  assign bus.saida        = r_saida;
  assign bus.saida_valida = r_saida_valida;
  assign bus.canal_saida  = r_canal_saida;
  assign bus.erro_seletor = r_erro_seletor;

endmodule
